// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready backpressure, flush and tag
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic               st_valid [SHAMT_W];
  logic [WIDTH-1:0]   st_data  [SHAMT_W];
  logic [SHAMT_W-1:0] st_shamt [SHAMT_W];
  logic [1:0]         st_op    [SHAMT_W];
  logic [TAG_W-1:0]   st_tag   [SHAMT_W];
  logic               st_sign  [SHAMT_W];

  logic               src_valid [SHAMT_W];
  logic [WIDTH-1:0]   src_data  [SHAMT_W];
  logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
  logic [1:0]         src_op    [SHAMT_W];
  logic [TAG_W-1:0]   src_tag   [SHAMT_W];
  logic               src_sign  [SHAMT_W];
  logic [WIDTH-1:0]   nxt_data  [SHAMT_W];

  logic adv;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic             sgn,
    input logic [1:0]       op,
    input int               s
  );
    logic [WIDTH-1:0] ones;
    ones = '1;
    case (op)
      OP_SLL:  shift_step = d << s;
      OP_SRL:  shift_step = d >> s;
      OP_SRA:  shift_step = (d >> s) | ({WIDTH{sgn}} & ~(ones >> s));
      default: shift_step = (d >> s) | (d << (WIDTH - s));
    endcase
  endfunction

  assign adv       = !st_valid[SHAMT_W-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = st_valid[SHAMT_W-1];
  assign out_data  = st_data[SHAMT_W-1];
  assign out_tag   = st_tag[SHAMT_W-1];

  // The shamt field is shifted left at every stage, so each stage only ever inspects its MSB.
  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = in_op;
    src_tag[0]   = in_tag;
    src_sign[0]  = in_data[WIDTH-1];
    for (int k = 1; k < SHAMT_W; k++) begin
      src_valid[k] = st_valid[k-1];
      src_data[k]  = st_data[k-1];
      src_shamt[k] = st_shamt[k-1];
      src_op[k]    = st_op[k-1];
      src_tag[k]   = st_tag[k-1];
      src_sign[k]  = st_sign[k-1];
    end
    for (int k = 0; k < SHAMT_W; k++) begin
      nxt_data[k] = src_data[k];
      if (src_shamt[k][SHAMT_W-1])
        nxt_data[k] = shift_step(src_data[k], src_sign[k], src_op[k], 1 << (SHAMT_W - 1 - k));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        st_valid[k] <= 1'b0;
        st_data[k]  <= '0;
        st_shamt[k] <= '0;
        st_op[k]    <= '0;
        st_tag[k]   <= '0;
        st_sign[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SHAMT_W; k++) begin
        if (flush)
          st_valid[k] <= 1'b0;
        else if (adv)
          st_valid[k] <= src_valid[k];
        if (adv) begin
          st_data[k]  <= nxt_data[k];
          st_shamt[k] <= src_shamt[k] << 1;
          st_op[k]    <= src_op[k];
          st_tag[k]   <= src_tag[k];
          st_sign[k]  <= src_sign[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - self-checking bench for shift_pipe at WIDTH=32 and WIDTH=8
`timescale 1ns/1ps
module tb_shift_pipe;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        flush = 1'b0;
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [31:0] a_in_data = '0, a_out_data;
  logic [4:0]  a_in_shamt = '0, a_in_tag = '0, a_out_tag;
  logic [1:0]  a_in_op = '0;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [7:0]  b_in_data = '0, b_out_data;
  logic [2:0]  b_in_shamt = '0;
  logic [1:0]  b_in_op = '0, b_in_tag = '0, b_out_tag;

  shift_pipe #(.WIDTH(32), .TAG_W(5)) dut_a (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shamt(a_in_shamt), .in_op(a_in_op), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag)
  );

  shift_pipe #(.WIDTH(8), .TAG_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shamt(b_in_shamt), .in_op(b_in_op), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: plain shift operators on a 64-bit container, sign extension via >>>.
  function automatic logic [31:0] model(input int w, input logic [1:0] op, input logic [31:0] d, input int sh);
    logic [63:0] mask, x, r;
    mask = (64'd1 << w) - 64'd1;
    x = {32'd0, d} & mask;
    case (op)
      2'd0: r = x << sh;
      2'd1: r = x >> sh;
      2'd2: begin
        if (x[w-1]) x = x | ~mask;
        r = $signed(x) >>> sh;
      end
      default: r = (x | (x << w)) >> sh;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  logic [36:0] qa[$];
  logic [9:0]  qb[$];
  logic        a_stall = 1'b0, b_stall = 1'b0;
  logic [36:0] a_prev;
  logic [9:0]  b_prev;

  always @(negedge clock) begin
    logic [36:0] e;
    if (!reset_n) begin
      qa.delete();
      a_stall = 1'b0;
    end else begin
      if (a_stall) begin
        chk("a_hold_valid", a_out_valid, 1);
        chk("a_hold_data", {a_out_tag, a_out_data}, a_prev);
      end
      chk("a_in_ready", a_in_ready, !(a_out_valid && !a_out_ready));
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_unexpected_out", a_out_valid, 0);
        else begin
          e = qa.pop_front();
          chk("a_result", {a_out_tag, a_out_data}, e);
        end
      end
      if (flush) qa.delete();
      else if (a_in_valid && a_in_ready)
        qa.push_back({a_in_tag, model(32, a_in_op, a_in_data, int'(a_in_shamt))});
      a_stall = a_out_valid && !a_out_ready;
      a_prev = {a_out_tag, a_out_data};
    end
  end

  always @(negedge clock) begin
    logic [31:0] m;
    logic [9:0]  e;
    if (!reset_n) begin
      qb.delete();
      b_stall = 1'b0;
    end else begin
      if (b_stall) chk("b_hold_data", {b_out_tag, b_out_data}, b_prev);
      chk("b_in_ready", b_in_ready, !(b_out_valid && !b_out_ready));
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_unexpected_out", b_out_valid, 0);
        else begin
          e = qb.pop_front();
          chk("b_result", {b_out_tag, b_out_data}, e);
        end
      end
      if (b_in_valid && b_in_ready) begin
        m = model(8, b_in_op, {24'd0, b_in_data}, int'(b_in_shamt));
        qb.push_back({b_in_tag, m[7:0]});
      end
      b_stall = b_out_valid && !b_out_ready;
      b_prev = {b_out_tag, b_out_data};
    end
  end

  task automatic a_issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh, input logic [4:0] tag);
    logic ok;
    int n;
    n = 0;
    a_in_valid = 1'b1; a_in_op = op; a_in_data = d; a_in_shamt = sh; a_in_tag = tag;
    do begin
      @(negedge clock);
      ok = a_in_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("a_issue_timeout", a_in_ready, 1);
    a_in_valid = 1'b0;
  endtask

  task automatic b_issue(input logic [1:0] op, input logic [7:0] d, input logic [2:0] sh, input logic [1:0] tag);
    logic ok;
    int n;
    n = 0;
    b_in_valid = 1'b1; b_in_op = op; b_in_data = d; b_in_shamt = sh; b_in_tag = tag;
    do begin
      @(negedge clock);
      ok = b_in_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("b_issue_timeout", b_in_ready, 1);
    b_in_valid = 1'b0;
  endtask

  // Single op on an idle pipe: edges after acceptance until out_valid, then the literal result.
  task automatic a_single(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                          input logic [4:0] tag, input logic [31:0] exp);
    int lat;
    lat = -1;
    a_out_ready = 1'b1;
    a_issue(op, d, sh, tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (a_out_valid) begin
        lat = i;
        break;
      end
    end
    chk("a_latency", lat, 4);
    chk("a_literal_data", a_out_data, exp);
    chk("a_literal_tag", a_out_tag, tag);
    @(posedge clock);
    #1;
  endtask

  task automatic a_drain();
    a_out_ready = 1'b1;
    for (int i = 0; i < 100 && qa.size() != 0; i++) @(posedge clock);
    #1;
    chk("a_drain_empty", qa.size(), 0);
  endtask

  logic [1:0]  v_op [11] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
  logic [31:0] v_d  [11] = '{32'h80000000, 32'h80000000, 32'h00000001, 32'h00000001, 32'hDEADBEEF,
                             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h7FFFFFFF, 32'h80000001,
                             32'h12345678};
  logic [4:0]  v_sh [11] = '{5'd4, 5'd4, 5'd31, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd8};
  logic [31:0] v_ex [11] = '{32'hF8000000, 32'h08000000, 32'h80000000, 32'h80000000, 32'hDEADBEEF,
                             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF,
                             32'h78123456};

  logic stream_done = 1'b0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat;
    logic [4:0] t5;

    @(posedge clock);
    #1;
    chk("reset_a_out_valid", a_out_valid, 0);
    chk("reset_a_out_data", a_out_data, 0);
    chk("reset_a_out_tag", a_out_tag, 0);
    chk("reset_a_in_ready", a_in_ready, 1);
    chk("reset_b_out_valid", b_out_valid, 0);
    chk("reset_b_in_ready", b_in_ready, 1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      chk("model_pin", model(32, v_op[i], v_d[i], int'(v_sh[i])), v_ex[i]);
      t5 = 5'(i + 1);
      a_single(v_op[i], v_d[i], v_sh[i], t5, v_ex[i]);
    end

    // Streaming with random backpressure
    stream_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 20; t++)
          a_issue(2'($urandom), $urandom, 5'($urandom), 5'(t));
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clock);
          #1;
          a_out_ready = 1'($urandom);
        end
      end
    join
    a_drain();

    // Fill with out_ready low: in_ready must drop after exactly 5 acceptances
    a_out_ready = 1'b0;
    acc = 0;
    a_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_in_op = 2'(i); a_in_data = 32'hA5000000 + 32'(i); a_in_shamt = 5'(3 * i); a_in_tag = 5'(i + 20);
      @(negedge clock);
      if (!a_in_ready) break;
      @(posedge clock);
      #1;
      acc++;
    end
    chk("fill_accept_count", acc, 5);
    chk("fill_out_valid", a_out_valid, 1);
    @(posedge clock);
    #1;
    a_in_valid = 1'b0;
    a_drain();

    // Flush with a simultaneous input
    for (int i = 0; i < 3; i++) a_issue(2'd1, 32'hF0F0F0F0, 5'(i), 5'(i));
    a_in_valid = 1'b1; a_in_op = 2'd0; a_in_data = 32'h1; a_in_shamt = 5'd2; a_in_tag = 5'd9;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    a_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("flush_quiet", a_out_valid, 0);
    end
    @(posedge clock);
    #1;
    a_single(2'd3, 32'h000000F1, 5'd4, 5'd17, 32'h1000000F);

    // Asynchronous reset with ops in flight
    for (int i = 0; i < 4; i++) a_issue(2'd2, 32'h8000FFFF, 5'(i + 1), 5'(i + 10));
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_out_valid", a_out_valid, 0);
    chk("midreset_out_data", a_out_data, 0);
    chk("midreset_out_tag", a_out_tag, 0);
    chk("midreset_in_ready", a_in_ready, 1);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("postreset_quiet", a_out_valid, 0);
    end
    @(posedge clock);
    #1;

    // WIDTH=8: latency and literal, then exhaustive sweep
    chk("model_pin_b", model(8, 2'd2, 32'h80, 3), 32'hF0);
    b_issue(2'd2, 8'h80, 3'd3, 2'd1);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (b_out_valid) begin
        lat = i;
        break;
      end
    end
    chk("b_latency", lat, 2);
    chk("b_literal_data", b_out_data, 8'hF0);
    @(posedge clock);
    #1;
    for (int op = 0; op < 4; op++)
      for (int sh = 0; sh < 8; sh++)
        for (int d = 0; d < 256; d++)
          b_issue(2'(op), 8'(d), 3'(sh), 2'(d));
    for (int i = 0; i < 100 && qb.size() != 0; i++) @(posedge clock);
    #1;
    chk("b_drain_empty", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
